lsu_mem_master: RTL and testbench

- Load/store initiator that drives the data-memory port (write_enable / width / sign_extend / address / data_in / data_out) on behalf of the core.
- Accepts one request at a time on a valid/ready handshake and issues the memory accesses.
- Misaligned halfword/word accesses are split into sequential byte accesses; load data is reassembled and sign/zero-extended internally.
- Sits between the execute stage and the data memory.

---
 rtl/lsu_mem_master.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator driving the data-memory port for the core.
// One request at a time on a valid/ready handshake. Misaligned halfword/word
// accesses are split into sequential byte accesses and reassembled little-endian.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned requests with
// resp_error instead of splitting them.

package lsu_mem_pkg;
    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        HALFWORD = 2'b01,
        WORD     = 2'b10
    } mem_width_t;
endpackage

module lsu_mem_master
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  mem_width_t            req_width,
    input  logic                  req_sign_extend,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output mem_width_t            mem_width,
    output logic                  mem_sign_extend,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  write_q;
    mem_width_t            width_q;
    logic                  sext_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  split_q;
    logic                  error_q;
    logic [1:0]            idx;
    logic [1:0]            last_idx;
    logic [31:0]           asm_q;

    logic                  req_legal;
    logic                  req_misaligned;
    logic                  req_error;
    logic                  req_split;
    logic [1:0]            idx_next;
    logic [31:0]           asm_next;
    logic [31:0]           load_data;

    // The memory never sign-extends; extension is done here after reassembly.
    assign mem_sign_extend = 1'b0;

    function automatic logic is_misaligned(input mem_width_t w, input logic [1:0] a);
        return ((w == HALFWORD) && a[0]) || ((w == WORD) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] d, input logic [1:0] k,
                                                input logic [7:0] b);
        logic [31:0] r;
        r = d;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input mem_width_t w,
                                                input logic s);
        case (w)
            BYTE:     return {{24{s & d[7]}}, d[7:0]};
            HALFWORD: return {{16{s & d[15]}}, d[15:0]};
            default:  return d;
        endcase
    endfunction

    // Classify the incoming request: legal width, alignment, split or error.
    always_comb begin
        req_legal      = (req_width == BYTE) || (req_width == HALFWORD) || (req_width == WORD);
        req_misaligned = req_legal && is_misaligned(req_width, req_address[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_error      = !req_legal || req_misaligned;
        req_split      = 1'b0;
`else
        req_error      = !req_legal;
        req_split      = req_misaligned;
`endif
    end

    // Next byte index and the load word with the current byte merged in.
    always_comb begin
        idx_next  = idx + 2'd1;
        asm_next  = insert_byte(asm_q, idx, mem_rdata[7:0]);
        load_data = split_q ? asm_next : mem_rdata;
    end

    // Request FSM; all memory-port and response outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= 32'h0;
            resp_error       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_width        <= WORD;
            mem_address      <= '0;
            mem_wdata        <= 32'h0;
            write_q          <= 1'b0;
            width_q          <= WORD;
            sext_q           <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= 32'h0;
            split_q          <= 1'b0;
            error_q          <= 1'b0;
            idx              <= 2'd0;
            last_idx         <= 2'd0;
            asm_q            <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state            <= ACCESS;
                        req_ready        <= 1'b0;
                        write_q          <= req_write;
                        width_q          <= req_width;
                        sext_q           <= req_sign_extend;
                        addr_q           <= req_address;
                        wdata_q          <= req_wdata;
                        split_q          <= req_split;
                        error_q          <= req_error;
                        idx              <= 2'd0;
                        last_idx         <= req_split ? ((req_width == WORD) ? 2'd3 : 2'd1) : 2'd0;
                        asm_q            <= 32'h0;
                        // First (or only) access is presented during the first ACCESS cycle.
                        mem_write_enable <= req_write && !req_error;
                        mem_width        <= req_error ? WORD : (req_split ? BYTE : req_width);
                        mem_address      <= req_address;
                        mem_wdata        <= req_wdata;
                    end
                end
                ACCESS: begin
                    if (split_q && (idx != last_idx)) begin
                        idx         <= idx_next;
                        asm_q       <= asm_next;
                        mem_address <= addr_q + ADDR_WIDTH'(idx_next);
                        mem_wdata   <= wdata_q >> {idx_next, 3'b000};
                    end else begin
                        state            <= RESP;
                        mem_write_enable <= 1'b0;
                        resp_valid       <= 1'b1;
                        resp_error       <= error_q;
                        resp_rdata       <= (error_q || write_q) ? 32'h0
                                            : extend_load(load_data, width_q, sext_q);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state            <= IDLE;
                    req_ready        <= 1'b1;
                    resp_valid       <= 1'b0;
                    mem_write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench for lsu_mem_master with a byte-array memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.

module tb_lsu_mem_master;
    import lsu_mem_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    mem_width_t    req_width;
    logic          req_sign_extend;
    logic [AW-1:0] req_address;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_write_enable;
    mem_width_t    mem_width;
    logic          mem_sign_extend;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    mem [256];
    logic          mem_clr;
    logic [AW-1:0] a1, a2, a3;

    logic [AW-1:0] addr_log  [8];
    logic [1:0]    width_log [8];
    logic          we_log    [8];
    int            nlog;

    lsu_mem_master #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_width        (req_width),
        .req_sign_extend  (req_sign_extend),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_width        (mem_width),
        .mem_sign_extend  (mem_sign_extend),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    assign a1 = mem_address + 8'd1;
    assign a2 = mem_address + 8'd2;
    assign a3 = mem_address + 8'd3;

    // Combinational zero-extended read, like the real data memory.
    always_comb begin
        mem_rdata = 32'h0;
        case (mem_width)
            BYTE:     mem_rdata = {24'h0, mem[mem_address]};
            HALFWORD: mem_rdata = {16'h0, mem[a1], mem[mem_address]};
            WORD:     mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_address]};
            default:  mem_rdata = 32'h0;
        endcase
    end

    // Synchronous write port plus a bench-side clear.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_write_enable) begin
            case (mem_width)
                BYTE: mem[mem_address] <= mem_wdata[7:0];
                HALFWORD: begin
                    mem[mem_address] <= mem_wdata[7:0];
                    mem[a1]          <= mem_wdata[15:8];
                end
                WORD: begin
                    mem[mem_address] <= mem_wdata[7:0];
                    mem[a1]          <= mem_wdata[15:8];
                    mem[a2]          <= mem_wdata[23:16];
                    mem[a3]          <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction: handshake, log every ACCESS cycle, check the response.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] w, input logic sx,
                          input logic [AW-1:0] a, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), 32'h1);
        req_valid       = 1'b1;
        req_write       = wr;
        req_width       = mem_width_t'(w);
        req_sign_extend = sx;
        req_address     = a;
        req_wdata       = wd;
        @(negedge clk);
        // Scramble request fields; they must be ignored from here on.
        req_valid       = 1'b0;
        req_write       = ~wr;
        req_address     = ~a;
        req_wdata       = ~wd;
        cyc  = 1;
        nlog = 0;
        while (!resp_valid && cyc < 12) begin
            if (nlog < 8) begin
                addr_log[nlog]  = mem_address;
                width_log[nlog] = mem_width;
                we_log[nlog]    = mem_write_enable;
                nlog++;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"},   32'(cyc), 32'(exp_lat));
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"},   32'(resp_error), 32'(exp_err));
        chk({tag, ".we_resp"}, 32'(mem_write_enable), 32'h0);
        @(negedge clk);
        chk({tag, ".strobe"}, 32'(resp_valid), 32'h0);
    endtask

    function automatic logic any_we();
        logic r;
        r = 1'b0;
        for (int i = 0; i < nlog; i++) r = r | we_log[i];
        return r;
    endfunction

    initial begin
        rst_n           = 1'b0;
        mem_clr         = 1'b1;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_width       = WORD;
        req_sign_extend = 1'b0;
        req_address     = '0;
        req_wdata       = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'h1);
        chk("rst.resp_valid", 32'(resp_valid), 32'h0);
        chk("rst.we", 32'(mem_write_enable), 32'h0);
        chk("rst.width", 32'(mem_width), 32'(WORD));
        chk("rst.addr", 32'(mem_address), 32'h0);
        chk("rst.sext", 32'(mem_sign_extend), 32'h0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        // Reset in the middle of a split word store, after two byte writes.
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_width   = WORD;
        req_address = 8'h11;
        req_wdata   = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("split.addr_k2", 32'(mem_address), 32'h13);
        chk("split.we_k2", 32'(mem_write_enable), 32'h1);
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", 32'(req_ready), 32'h1);
        chk("midrst.resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst.rdata", resp_rdata, 32'h0);
        chk("midrst.err", 32'(resp_error), 32'h0);
        chk("midrst.we", 32'(mem_write_enable), 32'h0);
        chk("midrst.addr", 32'(mem_address), 32'h0);
        chk("midrst.wdata", mem_wdata, 32'h0);
        chk("midrst.width", 32'(mem_width), 32'(WORD));
        @(negedge clk);
        rst_n = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("midrst.m11", 32'(mem[8'h11]), 32'h00);
        chk("midrst.m12", 32'(mem[8'h12]), 32'h00);
`else
        chk("midrst.m10", 32'(mem[8'h10]), 32'h00);
        chk("midrst.m11", 32'(mem[8'h11]), 32'hDD);
        chk("midrst.m12", 32'(mem[8'h12]), 32'hCC);
        chk("midrst.m13", 32'(mem[8'h13]), 32'h00);
`endif

        // Aligned store then load.
        do_req("st_w10", 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        chk("st_w10.m13", 32'(mem[8'h13]), 32'hDE);
        do_req("ld_w10", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // Sign/zero extension.
        do_req("st_w20", 1'b1, 2'b10, 1'b0, 8'h20, 32'h000080F0, 2, 32'h0, 1'b0);
        do_req("ld_bs20", 1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 2, 32'hFFFFFFF0, 1'b0);
        do_req("ld_bz20", 1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 2, 32'h000000F0, 1'b0);
        do_req("ld_hz20", 1'b0, 2'b01, 1'b0, 8'h20, 32'h0, 2, 32'h000080F0, 1'b0);
        do_req("ld_hs20", 1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 2, 32'hFFFF80F0, 1'b0);

        // Misaligned word load of bytes 11 22 33 44 at 0x11..0x14.
        do_req("st_b11", 1'b1, 2'b00, 1'b0, 8'h11, 32'hFFFFFF11, 2, 32'h0, 1'b0);
        do_req("st_b12", 1'b1, 2'b00, 1'b0, 8'h12, 32'h00000022, 2, 32'h0, 1'b0);
        do_req("st_b13", 1'b1, 2'b00, 1'b0, 8'h13, 32'h00000033, 2, 32'h0, 1'b0);
        do_req("st_b14", 1'b1, 2'b00, 1'b0, 8'h14, 32'h00000044, 2, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("ld_w11", 1'b0, 2'b10, 1'b0, 8'h11, 32'h0, 2, 32'h0, 1'b1);
        chk("ld_w11.naccess", 32'(nlog), 32'd1);
`else
        do_req("ld_w11", 1'b0, 2'b10, 1'b0, 8'h11, 32'h0, 5, 32'h44332211, 1'b0);
        chk("ld_w11.naccess", 32'(nlog), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ld_w11.addr%0d", k), 32'(addr_log[k]), 32'h11 + 32'(k));
            chk($sformatf("ld_w11.width%0d", k), 32'(width_log[k]), 32'(BYTE));
        end
        chk("ld_w11.we", 32'(any_we()), 32'h0);
`endif

        // Misaligned halfword store/load at 0x31.
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("st_h31", 1'b1, 2'b01, 1'b0, 8'h31, 32'h000080A5, 2, 32'h0, 1'b1);
        chk("st_h31.we", 32'(any_we()), 32'h0);
        chk("st_h31.m31", 32'(mem[8'h31]), 32'h00);
        chk("st_h31.m32", 32'(mem[8'h32]), 32'h00);
        do_req("ld_h31", 1'b0, 2'b01, 1'b1, 8'h31, 32'h0, 2, 32'h0, 1'b1);
`else
        do_req("st_h31", 1'b1, 2'b01, 1'b0, 8'h31, 32'h000080A5, 3, 32'h0, 1'b0);
        chk("st_h31.m31", 32'(mem[8'h31]), 32'hA5);
        chk("st_h31.m32", 32'(mem[8'h32]), 32'h80);
        do_req("ld_h31", 1'b0, 2'b01, 1'b1, 8'h31, 32'h0, 3, 32'hFFFF80A5, 1'b0);
`endif
        // Aligned traffic after a misaligned one.
        do_req("ld_w10b", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 32'h332211EF, 1'b0);

        // Address wrap at the top of memory.
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("st_hff", 1'b1, 2'b01, 1'b0, 8'hFF, 32'h0000BEEF, 2, 32'h0, 1'b1);
        chk("st_hff.mff", 32'(mem[8'hFF]), 32'h00);
        chk("st_hff.m00", 32'(mem[8'h00]), 32'h00);
`else
        do_req("st_hff", 1'b1, 2'b01, 1'b0, 8'hFF, 32'h0000BEEF, 3, 32'h0, 1'b0);
        chk("st_hff.mff", 32'(mem[8'hFF]), 32'hEF);
        chk("st_hff.m00", 32'(mem[8'h00]), 32'hBE);
`endif

        // Illegal width encoding: no access, error response.
        do_req("st_ill", 1'b1, 2'b11, 1'b0, 8'h40, 32'h12345678, 2, 32'h0, 1'b1);
        chk("st_ill.we", 32'(any_we()), 32'h0);
        chk("st_ill.m40", 32'(mem[8'h40]), 32'h00);
        do_req("ld_ill", 1'b0, 2'b11, 1'b1, 8'h20, 32'h0, 2, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
